// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the issue logic and alu_sequencer.
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [13:0] req_cntl;
   logic [31:0] req_opnd0;
   logic [31:0] req_opnd1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [31:0] rsp_remainder;
   logic [6:0]  rsp_status;
   logic        rsp_div_zero;

   // Requester / response consumer side
   modport master (
      output req_valid, req_cntl, req_opnd0, req_opnd1, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_remainder, rsp_status, rsp_div_zero
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_cntl, req_opnd0, req_opnd1, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_remainder, rsp_status, rsp_div_zero
   );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the execute-stage ALU: registers ALU inputs,
// captures results, owns the flags register and runs a 32-step restoring divide.
module alu_sequencer (
   input  logic                  clk,
   input  logic                  rst,
   alu_sequencer_if.slave        bus,
   output logic [6:0]            flags,
   input  logic                  flags_ld,
   input  logic [6:0]            flags_ld_data,
   output logic [13:0]           alu_cntl,
   output logic [31:0]           alu_opnd0,
   output logic [31:0]           alu_opnd1,
   output logic [6:0]            alu_status_in,
   input  logic [31:0]           alu_result,
   input  logic [6:0]            alu_status_out
);
   // Control-word bit positions (ALU_* in defines.v)
   localparam int ALU_OP_ADD    = 0;
   localparam int ALU_OP_SUB    = 1;
   localparam int ALU_OP_AND    = 2;
   localparam int ALU_OP_OR     = 3;
   localparam int ALU_OP_XOR    = 4;
   localparam int ALU_OP_MUL    = 5;
   localparam int ALU_NO_WR     = 7;

   localparam logic [13:0] OP_MASK = (14'd1 << ALU_OP_ADD) | (14'd1 << ALU_OP_SUB) |
                                     (14'd1 << ALU_OP_AND) | (14'd1 << ALU_OP_OR)  |
                                     (14'd1 << ALU_OP_XOR) | (14'd1 << ALU_OP_MUL);

   typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;

   state_t      state, state_nxt;
   logic        accept, exec_cap, div_step, div_last, rsp_done;
   logic        is_div, div_by_zero;

   logic [13:0] cntl_q;
   logic [31:0] opnd0_q, opnd1_q;
   logic [31:0] rem_q, quo_q;
   logic [4:0]  step_q;
   logic [6:0]  flags_q;
   logic [31:0] rsp_result_q, rsp_remainder_q;
   logic [6:0]  rsp_status_q;
   logic        rsp_div_zero_q;

   logic [32:0] div_s;
   logic        div_ge;
   logic [31:0] div_r, div_q;

   assign is_div      = ~|(bus.req_cntl & OP_MASK);
   assign div_by_zero = (bus.req_opnd1 == '0);

   // One restoring-divide step; the partial remainder is always below the
   // 32-bit divisor, so only the shifted-in value needs the 33rd bit.
   always_comb begin
      div_s  = {rem_q, quo_q[31]};
      div_ge = (div_s >= {1'b0, opnd1_q});
      div_r  = div_ge ? 32'(div_s - {1'b0, opnd1_q}) : div_s[31:0];
      div_q  = {quo_q[30:0], div_ge};
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      exec_cap  = 1'b0;
      div_step  = 1'b0;
      div_last  = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: if (bus.req_valid) begin
            accept = 1'b1;
            if (!is_div)          state_nxt = EXEC;
            else if (div_by_zero) state_nxt = RESP;
            else                  state_nxt = DIV;
         end
         EXEC: begin
            exec_cap  = 1'b1;
            state_nxt = RESP;
         end
         DIV: begin
            div_step = 1'b1;
            if (step_q == 5'd31) begin
               div_last  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: if (bus.rsp_ready) begin
            rsp_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, divider iteration and response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cntl_q          <= '0;
         opnd0_q         <= '0;
         opnd1_q         <= '0;
         rem_q           <= '0;
         quo_q           <= '0;
         step_q          <= '0;
         rsp_result_q    <= '0;
         rsp_remainder_q <= '0;
         rsp_status_q    <= '0;
         rsp_div_zero_q  <= 1'b0;
      end else begin
         if (accept) begin
            cntl_q  <= bus.req_cntl;
            opnd0_q <= bus.req_opnd0;
            opnd1_q <= bus.req_opnd1;
            rem_q   <= '0;
            quo_q   <= bus.req_opnd0;
            step_q  <= '0;
            if (is_div && div_by_zero) begin
               rsp_result_q    <= '1;
               rsp_remainder_q <= bus.req_opnd0;
               rsp_status_q    <= flags_q;
               rsp_div_zero_q  <= 1'b1;
            end
         end
         if (exec_cap) begin
            rsp_result_q    <= alu_result;
            rsp_remainder_q <= '0;
            rsp_status_q    <= alu_status_out;
         end
         if (div_step) begin
            rem_q  <= div_r;
            quo_q  <= div_q;
            step_q <= step_q + 5'd1;
         end
         if (div_last) begin
            rsp_result_q    <= cntl_q[ALU_NO_WR] ? '0 : div_q;
            rsp_remainder_q <= cntl_q[ALU_NO_WR] ? '0 : div_r;
            rsp_status_q    <= flags_q;
         end
         if (rsp_done) rsp_div_zero_q <= 1'b0;
      end
   end

   // Architectural flags: explicit loads take priority over ALU status capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           flags_q <= '0;
      else if (flags_ld) flags_q <= flags_ld_data;
      else if (exec_cap) flags_q <= alu_status_out;
   end

   assign bus.req_ready     = (state == IDLE);
   assign bus.rsp_valid     = (state == RESP);
   assign bus.rsp_result    = rsp_result_q;
   assign bus.rsp_remainder = rsp_remainder_q;
   assign bus.rsp_status    = rsp_status_q;
   assign bus.rsp_div_zero  = rsp_div_zero_q;

   assign flags         = flags_q;
   assign alu_status_in = flags_q;
   assign alu_cntl      = cntl_q;
   assign alu_opnd0     = opnd0_q;
   assign alu_opnd1     = opnd1_q;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the execute-stage ALU. It accepts decoded ALU requests over a valid/ready handshake and drives the combinational ALU's control, operand and status inputs from registers. It captures the ALU's result and status into a response register and owns the architectural 7-bit status (flags) register that feeds the ALU's status input. Divide is executed iteratively here, a 32-step restoring divider, so the combinational ALU divide path is never selected.

## Interface
- No parameters; data width fixed at 32, status width 7, control width 14. Bit positions come from `defines.v` (`ALU_*`, `STAT_*`).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept.
- `req_cntl`  in  14  ALU control word.
- `req_opnd0`, `req_opnd1`  in  32 each  operands; opnd0 is the dividend for divide.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  downstream accepts response.
- `rsp_result`  out  32  result or quotient.
- `rsp_remainder`  out  32  divide remainder; 0 for non-divide.
- `rsp_status`  out  7  status after the op.
- `rsp_div_zero`  out  1  divide by zero occurred.
- `flags`  out  7  architectural status register.
- `flags_ld`  in  1  load flags from `flags_ld_data` (POPF/STD/CLD path).
- `flags_ld_data`  in  7  value for `flags_ld`.
- `alu_cntl`  out  14  to ALU control input.
- `alu_opnd0`, `alu_opnd1`  out  32 each  to ALU operand inputs.
- `alu_status_in`  out  7  to ALU status input; always equals `flags`.
- `alu_result`  in  32  from ALU result output.
- `alu_status_out`  in  7  from ALU status output.

## Operation
- Divide op: none of `ALU_OP_ADD/SUB/AND/OR/XOR/MUL` set in `req_cntl`. Any other op is an ALU op.
- States: IDLE, EXEC, DIV, RESP. `req_ready` = (state == IDLE). Accept occurs on `req_valid & req_ready`.
- On accept, latch `cntl`, `opnd0` and `opnd1` into registers. `alu_cntl`, `alu_opnd0` and `alu_opnd1` are driven only from these registers.
- Transitions on accept:
  - ALU op: IDLE→EXEC.
  - Divide with `req_opnd1 == 0`: IDLE→RESP.
  - Divide otherwise: IDLE→DIV, with step counter = 0.
- EXEC (one cycle): at the end of the cycle, capture `rsp_result ← alu_result`, `rsp_status ← alu_status_out`, `rsp_remainder ← 0`, and `flags ← alu_status_out`. Then EXEC→RESP.
- DIV: 33-bit partial remainder R and 32-bit quotient Q.
  - Init: R = 0, Q = dividend.
  - Each step: S = {R[31:0], Q[31]}. If S ≥ divisor, then R = S − divisor and Q = {Q[30:0], 1}; else R = S and Q = {Q[30:0], 0}.
  - After step 31: `rsp_result = Q`, `rsp_remainder = R[31:0]`. Then DIV→RESP.
- Divide status: `rsp_status = flags`; `flags` is unchanged.
- Divide by zero: `rsp_result = 32'hFFFF_FFFF`, `rsp_remainder = dividend`, `rsp_div_zero = 1`, flags unchanged.
- `ALU_NO_WR` on a divide: `rsp_result = 0`, `rsp_remainder = 0`, flags unchanged. The iteration still runs, so latency is the same.
- RESP: `rsp_valid = 1`. All `rsp_*` outputs are held stable until `rsp_ready`. On `rsp_ready`: RESP→IDLE, and `rsp_div_zero` clears.
- `flags_ld` is honoured in any state. In an EXEC capture cycle, `flags_ld` wins over `alu_status_out`; `rsp_status` still shows the ALU value.

## Timing
- Reset values: state IDLE, `req_ready = 1`, `rsp_valid = 0`, `rsp_result = 0`, `rsp_remainder = 0`, `rsp_status = 0`, `rsp_div_zero = 0`, `flags = 0`, `alu_cntl = 0`, `alu_opnd0 = 0`, `alu_opnd1 = 0`.
- Latency, for accept at edge N:
  - ALU op: `rsp_valid` high after edge N+2.
  - Divide: `rsp_valid` high after edge N+33.
  - Divide by zero: `rsp_valid` high after edge N+1.
- Throughput: at most one op in flight. No new request is accepted in the cycle the response is consumed, so the earliest next accept is the cycle after RESP→IDLE.
- `rst` mid-operation: the asynchronous reset aborts immediately to reset values. Any partially computed quotient and any held response are discarded.

## Test plan
- Flags 0; ADD 0xFFFF_FFFF + 0x1 (bench instantiates the real ALU) -> result 0x0, status CF=1, ZF=1, PF=1, AF=1, SF=0, OF=0. `rsp_valid` is high exactly 2 cycles after accept, and `flags` matches.
- Next, ADD with `ALU_USE_CARRY`, 5 + 3 with CF=1 -> result 9, CF=0, ZF=0.
- Divide 100 / 7 -> quotient 14, remainder 2. `rsp_valid` at accept+33; `flags` unchanged. Also 0xFFFF_FFFF / 1 -> quotient 0xFFFF_FFFF, remainder 0.
- Divide 55 / 0 -> `rsp_div_zero` = 1, result 0xFFFF_FFFF, remainder 55, `rsp_valid` at accept+1. `rsp_div_zero` is 0 after the handshake.
- Backpressure: hold `rsp_ready` low 5 cycles -> `rsp_*` stable and `req_ready` = 0 throughout. `flags_ld` = 7'h40 during the stall updates `flags` only.
- Assert `rst` at divide step 10 -> in the same cycle `rsp_valid` = 0 and `flags` = 0. After release `req_ready` = 1, and a fresh ADD completes normally.
